fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter for the 32-bit fifo_11 buffer. Shares the single FIFO
//  write port (w_en/data_in/full) between NUM_REQ producers using valid/ready handshakes.
//  Grants bursts of up to MAX_BURST words per requester and never writes while full.
//  Sits between producer blocks and fifo_11; the FIFO read side is untouched.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    32  data width, must match fifo_11 data_in
//  MAX_BURST 4   max words accepted per grant before rotating (1..15)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 asynchronous reset, active-high
//  req_valid    in   NUM_REQ           requester i has a word on its data slice
//  req_data     in   NUM_REQ*DATA_W    flat; slice i = [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ           word of requester i accepted this cycle if valid&ready
//  fifo_full    in   1                 from fifo_11 full
//  fifo_w_en    out  1                 to fifo_11 w_en
//  fifo_data_in out  DATA_W            to fifo_11 data_in
//  grant_id     out  clog2(NUM_REQ)    current/last granted requester
//  busy         out  1                 1 while in BURST state
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0; busy=0,
//    req_ready=0, fifo_w_en=0, fifo_data_in=0. Word in flight at reset is dropped.
//  - FSM IDLE: if any req_valid, pick first set index searching rr_ptr, rr_ptr+1, ...
//    mod NUM_REQ; register grant_id, burst_cnt=0, go BURST. Arbitration costs 1 cycle;
//    no word is accepted in IDLE.
//  - FSM BURST: req_ready[grant_id] = !fifo_full; all other ready=0 (combinational).
//    fifo_w_en = req_valid[grant_id] & !fifo_full; fifo_data_in = slice grant_id when
//    fifo_w_en, else 0. Each accepted word increments burst_cnt.
//  - Leave BURST -> IDLE, rr_ptr = grant_id+1 (wraps NUM_REQ-1 -> 0), when:
//    accepted word makes burst_cnt==MAX_BURST, or req_valid[grant_id]=0 in BURST.
//  - fifo_full in BURST: stall, stay in BURST, burst_cnt held, no timeout; grant kept.
//  - Requester may not drop valid mid-word expectation: dropping valid ends its burst.
//  - Simultaneous requests: only rr_ptr order matters; lowest index wins only when rr_ptr=0.
//  - Single requester repeatedly valid: re-granted after 1 IDLE cycle per burst.
//  - Throughput: MAX_BURST words per MAX_BURST+1 cycles when FIFO not full.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds ports stat_clr (in,1) and stat_cnt
//    (out, NUM_REQ*16, slice i = [i*16 +: 16]): per-requester accepted-word counters,
//    increment on each accepted word, saturate at 16'hFFFF, cleared by rst or stat_clr
//    (stat_clr wins over same-cycle increment).
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset: rst=1 mid-burst with req_valid=4'hF -> all outputs 0 same cycle; after
//    release first grant goes to req 0.
//  2 Round robin: req_valid=4'b1111 held, FIFO never full, MAX_BURST=4 -> grant order
//    0,1,2,3,0; 4 writes each, one idle cycle between bursts; data order preserved.
//  3 Full stall: req 2 granted, fifo_full=1 for 3 cycles after 2nd word -> fifo_w_en=0,
//    req_ready=0, grant_id=2 held; resumes, burst ends after words 3,4.
//  4 Short burst: req 1 sends 2 words (32'hA5A5_0001, 32'hA5A5_0002) then drops valid ->
//    exactly 2 writes, IDLE next cycle, rr_ptr=2.
//  5 Wrap: only req 3 and req 0 valid, rr_ptr=3 -> req 3 then req 0 granted.
//  6 FIFO_ARB_STATS_EN: 5 words from req 1, pulse stat_clr, 1 word -> stat_cnt[1]=5 then
//    0 then 1; others stay 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the single fifo_11 write port
// between NUM_REQ valid/ready producers. Each grant accepts up to MAX_BURST
// words; one arbitration cycle in IDLE precedes every burst.
// Optional feature macro: FIFO_ARB_STATS_EN adds stat_clr/stat_cnt with
// per-requester saturating accepted-word counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_w_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [NUM_REQ*16-1:0]       stat_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]   pick_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic              any_req_s;
  logic              accept_s;
  logic              burst_done_s;
  logic [DATA_W-1:0] slice_s [NUM_REQ];

  // Unpack the flat producer data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slice_s[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: first valid index searching from rr_ptr upward, wrapping.
  always_comb begin
    logic [ID_W:0] idx_v;
    logic          found_v;
    pick_s  = rr_ptr_q;
    found_v = 1'b0;
    idx_v   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_v = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
      if (idx_v >= (ID_W+1)'(NUM_REQ)) begin
        idx_v = idx_v - (ID_W+1)'(NUM_REQ);
      end else begin
        idx_v = idx_v;
      end
      if (!found_v && req_valid[idx_v[ID_W-1:0]]) begin
        found_v = 1'b1;
        pick_s  = idx_v[ID_W-1:0];
      end else begin
        found_v = found_v;
      end
    end
  end

  assign any_req_s    = |req_valid;
  assign accept_s     = (state_q == S_BURST) && req_valid[grant_q] && !fifo_full;
  assign burst_done_s = accept_s && ((burst_cnt_q + 4'd1) == 4'(MAX_BURST));
  assign next_ptr_s   = (grant_q == ID_W'(NUM_REQ-1)) ? '0 : grant_q + ID_W'(1);

  // FSM state register; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arbitrate in IDLE, leave BURST on full burst or dropped valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          state_d = S_BURST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (!req_valid[grant_q] || burst_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BURST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next grant, pointer and burst counter; fifo_full simply holds everything.
  always_comb begin
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          grant_d     = pick_s;
          burst_cnt_d = 4'd0;
        end else begin
          grant_d     = grant_q;
        end
      end
      S_BURST: begin
        if (accept_s) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        if (!req_valid[grant_q] || burst_done_s) begin
          rr_ptr_d = next_ptr_s;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      default: begin
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // Arbitration bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= 4'd0;
    end else begin
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // FSM outputs: only the granted requester sees ready, and only in BURST.
  always_comb begin
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    busy         = 1'b0;
    if (state_q == S_BURST) begin
      busy               = 1'b1;
      req_ready[grant_q] = !fifo_full;
      fifo_w_en          = accept_s;
      if (accept_s) begin
        fifo_data_in = slice_s[grant_q];
      end else begin
        fifo_data_in = '0;
      end
    end else begin
      busy = 1'b0;
    end
  end

  assign grant_id = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  // Per-requester accepted-word counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          stat_q[i] <= 16'd0;
        end else if (accept_s && (grant_q == ID_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end else begin
          stat_q[i] <= stat_q[i];
        end
      end
    end
  end

  // Pack counters onto the flat statistics bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt[i*16 +: 16] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=32, MAX_BURST=4).
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_data_in;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic              stat_clr;
  logic [NR*16-1:0]  stat_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cnt [NR];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int r, input int n);
    return {4'(r), 4'hA, 24'(n)};
  endfunction

  task automatic set_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i, cnt[i]);
  endtask

  // Advance one clock; producers move to their next word after a handshake.
  task automatic cycle();
    logic [NR-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (hs[i]) cnt[i]++;
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; req_data = '0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (fifo_w_en !== 1'b0) begin n_err++; $display("FAIL rst_wen got=%b exp=0", fifo_w_en); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
    req_valid = 4'b0010; set_data(); #1;
    cycle(); #1;
    n_cmp++; if (fifo_w_en !== 1'b1 || grant_id !== 2'd1) begin n_err++; $display("FAIL rst_pre wen=%b grant=%0d exp 1/1", fifo_w_en, grant_id); end
    rst = 1'b1; req_valid = 4'hF; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_cmp++; if (fifo_w_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_wen got=%b exp=0", fifo_w_en); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (fifo_data_in !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got=%h exp=0", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_mid_grant got=%0d exp=0", grant_id); end
    cycle();
    rst = 1'b0; set_data(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    cycle(); #1;
    n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_err++; $display("FAIL rst_first_grant busy=%b grant=%0d exp 1/0", busy, grant_id); end
    n_cmp++; if (fifo_data_in !== word_of(0, 0)) begin n_err++; $display("FAIL rst_first_data got=%h exp=%h", fifo_data_in, word_of(0, 0)); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    req_valid = 4'hF;
    for (int c = 0; c < 25; c++) begin
      int b, ph, g, w;
      logic          e_wen;
      logic [3:0]    e_rdy;
      logic [31:0]   e_dat;
      b = c / 5; ph = c % 5; g = b % 4; w = (b / 4) * 4 + ph - 1;
      e_wen = (ph != 0);
      e_rdy = (ph != 0) ? (4'b0001 << g) : 4'b0000;
      e_dat = (ph != 0) ? word_of(g, w) : 32'h0;
      set_data(); #1;
      n_cmp++; if (fifo_w_en !== e_wen) begin n_err++; $display("FAIL rr_wen c=%0d got=%b exp=%b", c, fifo_w_en, e_wen); end
      n_cmp++; if (busy !== e_wen) begin n_err++; $display("FAIL rr_busy c=%0d got=%b exp=%b", c, busy, e_wen); end
      n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, e_rdy); end
      n_cmp++; if (fifo_data_in !== e_dat) begin n_err++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, fifo_data_in, e_dat); end
      if (ph != 0) begin
        n_cmp++; if (grant_id !== 2'(g)) begin n_err++; $display("FAIL rr_grant c=%0d got=%0d exp=%0d", c, grant_id, g); end
      end
      cycle();
    end
  endtask

  task automatic test_full_stall();
    reset_dut();
    req_valid = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      logic        e_wen, e_busy;
      logic [31:0] e_dat;
      int          k;
      fifo_full = (c >= 3 && c <= 5);
      k = (c <= 2) ? c - 1 : c - 4;
      e_busy = (c >= 1 && c <= 7);
      e_wen  = (c == 1 || c == 2 || c == 6 || c == 7);
      e_dat  = e_wen ? word_of(2, k) : 32'h0;
      set_data(); #1;
      n_cmp++; if (fifo_w_en !== e_wen) begin n_err++; $display("FAIL stall_wen c=%0d got=%b exp=%b", c, fifo_w_en, e_wen); end
      n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL stall_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      n_cmp++; if (fifo_data_in !== e_dat) begin n_err++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, fifo_data_in, e_dat); end
      if (e_busy) begin
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL stall_grant c=%0d got=%0d exp=2", c, grant_id); end
        n_cmp++; if (req_ready !== (fifo_full ? 4'b0000 : 4'b0100)) begin n_err++; $display("FAIL stall_ready c=%0d got=%b", c, req_ready); end
      end
      cycle();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_short_burst();
    reset_dut();
    req_valid = 4'b0010; req_data[1*DW +: DW] = 32'hA5A5_0001; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sb_idle busy=%b exp=0", busy); end
    cycle(); #1;
    n_cmp++; if (fifo_w_en !== 1'b1 || fifo_data_in !== 32'hA5A5_0001) begin n_err++; $display("FAIL sb_w1 wen=%b data=%h exp 1/a5a50001", fifo_w_en, fifo_data_in); end
    cycle();
    req_data[1*DW +: DW] = 32'hA5A5_0002; #1;
    n_cmp++; if (fifo_w_en !== 1'b1 || fifo_data_in !== 32'hA5A5_0002) begin n_err++; $display("FAIL sb_w2 wen=%b data=%h exp 1/a5a50002", fifo_w_en, fifo_data_in); end
    cycle();
    req_valid = 4'b0000; #1;
    n_cmp++; if (fifo_w_en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL sb_drop wen=%b busy=%b exp 0/1", fifo_w_en, busy); end
    cycle();
    req_valid = 4'b0101; set_data(); #1;
    n_cmp++; if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin n_err++; $display("FAIL sb_idle2 busy=%b wen=%b exp 0/0", busy, fifo_w_en); end
    cycle(); #1;
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL sb_rrptr grant=%0d exp=2", grant_id); end
  endtask

  task automatic test_wrap();
    reset_dut();
    req_valid = 4'b0100; set_data(); #1;
    cycle(); #1;
    cycle();
    req_valid = 4'b0000; #1;
    cycle();
    req_valid = 4'b1001;
    for (int c = 0; c < 7; c++) begin
      set_data(); #1;
      if (c == 1 || c == 4) begin
        n_cmp++; if (grant_id !== 2'd3 || fifo_w_en !== 1'b1) begin n_err++; $display("FAIL wrap_g3 c=%0d grant=%0d wen=%b exp 3/1", c, grant_id, fifo_w_en); end
      end
      if (c == 5) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_idle busy=%b exp=0", busy); end
      end
      if (c == 6) begin
        n_cmp++; if (grant_id !== 2'd0 || fifo_data_in !== word_of(0, 0)) begin n_err++; $display("FAIL wrap_g0 grant=%0d data=%h exp 0/%h", grant_id, fifo_data_in, word_of(0, 0)); end
      end
      cycle();
    end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    reset_dut();
    req_valid = 4'b0010;
    for (int c = 0; c < 7; c++) begin set_data(); #1; cycle(); end
    req_valid = 4'b0000; #1;
    cycle();
    n_cmp++; if (stat_cnt[16 +: 16] !== 16'd5) begin n_err++; $display("FAIL stat_five got=%0d exp=5", stat_cnt[16 +: 16]); end
    n_cmp++; if ({stat_cnt[48 +: 16], stat_cnt[32 +: 16], stat_cnt[0 +: 16]} !== 48'h0) begin n_err++; $display("FAIL stat_others got=%h exp=0", stat_cnt); end
    stat_clr = 1'b1; #1;
    cycle();
    stat_clr = 1'b0; #1;
    n_cmp++; if (stat_cnt[16 +: 16] !== 16'd0) begin n_err++; $display("FAIL stat_clr got=%0d exp=0", stat_cnt[16 +: 16]); end
    req_valid = 4'b0010; set_data(); #1;
    cycle(); #1;
    cycle();
    req_valid = 4'b0000; #1;
    n_cmp++; if (stat_cnt[16 +: 16] !== 16'd1) begin n_err++; $display("FAIL stat_one got=%0d exp=1", stat_cnt[16 +: 16]); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_full_stall();
    test_short_burst();
    test_wrap();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
